// File: rtl/nonpu_pkg.sv
// Shared types and constants for the neuron spike path.
package nonpu_pkg;
  localparam int NONPU_ID_W  = 8;
  localparam int NONPU_V_W   = 16;
  localparam int NONPU_SRC_W = 4;

  localparam logic [NONPU_ID_W-1:0] NO_SPIKE_ID = '0;

  typedef struct packed {
    logic [NONPU_SRC_W-1:0] src;
    logic [NONPU_ID_W-1:0]  id;
    logic [NONPU_V_W-1:0]   v;
  } spike_evt_t;
endpackage

// File: rtl/spike_fifo.sv
// Generic synchronous FIFO with a registered head word and register-array storage.
module spike_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] head_nxt;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_nxt  = rd_ptr + AW'(do_pop);
  // Head is preloaded with whatever will sit at the read pointer next cycle,
  // bypassing the array when that slot is being written right now.
  assign head_nxt = (do_push && (wr_ptr == rd_nxt)) ? din : mem[rd_nxt];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nxt;
      level  <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      dout   <= head_nxt;
    end
  end
endmodule

// File: rtl/spike_arbiter.sv
// Round-robin merge of N_SRC spike sources into one tagged, FIFO-buffered stream.
module spike_arbiter
  import nonpu_pkg::*;
#(
  parameter  int N_SRC = 4,
  parameter  int ID_W  = NONPU_ID_W,
  parameter  int V_W   = NONPU_V_W,
  parameter  int DEPTH = 8,
  parameter  int SRC_W = $clog2(N_SRC),
  localparam int LW    = $clog2(DEPTH) + 1,
  localparam int EW    = SRC_W + ID_W + V_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic [N_SRC*ID_W-1:0] src_id,
  input  logic [N_SRC*V_W-1:0]  src_v,
  output logic [N_SRC-1:0]      src_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SRC_W-1:0]      out_src,
  output logic [ID_W-1:0]       out_id,
  output logic [V_W-1:0]        out_v,
  output logic [LW-1:0]         level,
  output logic [15:0]           stall_cnt
);
  logic [N_SRC-1:0] elig;
  logic [SRC_W-1:0] rr_ptr, gnt_idx;
  logic [SRC_W:0]   idx;
  logic             gnt_any, can_grant, full, empty, pop;
  logic [EW-1:0]    din, dout;

  for (genvar i = 0; i < N_SRC; i++) begin : g_elig
    assign elig[i] = src_valid[i] && (src_id[i*ID_W +: ID_W] != ID_W'(NO_SPIKE_ID));
  end

  // Gating on full alone (not full-and-popping) keeps out_ready off the grant path.
  assign can_grant = reset && !full;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (idx >= (SRC_W+1)'(N_SRC)) idx = idx - (SRC_W+1)'(N_SRC);
      if (!gnt_any && can_grant && elig[idx[SRC_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[SRC_W-1:0];
      end
    end
  end

  assign src_ready = gnt_any ? (N_SRC'(1) << gnt_idx) : '0;
  assign din       = {gnt_idx, src_id[gnt_idx*ID_W +: ID_W], src_v[gnt_idx*V_W +: V_W]};
  assign pop       = out_ready && !empty;
  assign out_valid = !empty;
  assign {out_src, out_id, out_v} = dout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      stall_cnt <= '0;
    end else begin
      if (gnt_any)
        rr_ptr <= (gnt_idx == SRC_W'(N_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
      if (|elig && !gnt_any && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  spike_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (gnt_any),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );
endmodule

// File: tb/tb_spike_arbiter.sv
// Directed-vector bench: stimulus queues expected FIFO outputs, a monitor pops and compares.
module tb_spike_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  src_valid = '0;
  logic [31:0] src_id = '0;
  logic [63:0] src_v = '0;
  logic [3:0]  src_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_src;
  logic [7:0]  out_id;
  logic [15:0] out_v;
  logic [3:0]  level;
  logic [15:0] stall_cnt;

  typedef struct packed {
    logic [1:0]  src;
    logic [7:0]  id;
    logic [15:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  spike_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .src_valid (src_valid),
    .src_id    (src_id),
    .src_v     (src_v),
    .src_ready (src_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .out_id    (out_id),
    .out_v     (out_v),
    .level     (level),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic vld, input logic [7:0] id, input logic [15:0] v);
    src_valid[i]       = vld;
    src_id[i*8 +: 8]   = id;
    src_v[i*16 +: 16]  = v;
  endtask

  task automatic expect_evt(input int s, input int id, input int v);
    exp_q.push_back('{src: 2'(s), id: 8'(id), v: 16'(v)});
  endtask

  task automatic clear_src();
    src_valid = '0;
    src_id    = '0;
    src_v     = '0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (level == 0) break;
      tick();
    end
    @(negedge clk);
    chk("drain_level", 32'(level), 0);
    chk("drain_queue", 32'(exp_q.size()), 0);
  endtask

  // Monitor: each accepted head word must match the oldest expected event.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_unexpected actual=0x%0h expected=none", {out_src, out_id, out_v});
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_evt", 32'({out_src, out_id, out_v}), 32'(e));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, with a request pending during reset
    set_src(0, 1'b1, 8'h11, 16'h1000);
    @(negedge clk);
    chk("rst_src_ready", 32'(src_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_out_data", 32'({out_src, out_id, out_v}), 0);
    tick();

    // Round-robin with all four sources eligible
    reset = 1'b1;
    out_ready = 1'b1;
    set_src(0, 1'b1, 8'h11, 16'h1000);
    set_src(1, 1'b1, 8'h22, 16'h2001);
    set_src(2, 1'b1, 8'h33, 16'h3002);
    set_src(3, 1'b1, 8'h44, 16'h4003);
    for (int k = 0; k < 8; k++) begin
      expect_evt(k % 4, (k % 4 + 1) * 8'h11, 16'h1000 * (k % 4 + 1) + k % 4);
      @(negedge clk);
      chk("rr_grant", 32'(src_ready), 32'(1 << (k % 4)));
      if (k > 0) chk("rr_level", 32'(level), 1);
      tick();
    end
    clear_src();
    drain();
    chk("rr_stall", 32'(stall_cnt), 0);

    // Id zero is never granted; rr_ptr is 0 here
    tick();
    set_src(0, 1'b1, 8'h00, 16'h0AAA);
    set_src(2, 1'b1, 8'h05, 16'hBEEF);
    expect_evt(2, 8'h05, 16'hBEEF);
    @(negedge clk);
    chk("id0_grant", 32'(src_ready), 32'b0100);
    tick();
    set_src(2, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    chk("id0_only_zero", 32'(src_ready), 0);
    chk("id0_stall", 32'(stall_cnt), 0);
    tick();
    clear_src();
    drain();

    // Full FIFO: rr_ptr is 3, so grants alternate src3, src1
    tick();
    out_ready = 1'b0;
    set_src(1, 1'b1, 8'h21, 16'h0101);
    set_src(3, 1'b1, 8'h23, 16'h0303);
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin
        if (k % 2 == 0) expect_evt(3, 8'h23, 16'h0303);
        else            expect_evt(1, 8'h21, 16'h0101);
      end
      @(negedge clk);
      chk("full_grant", 32'(src_ready), (k >= 8) ? 32'd0 : ((k % 2 == 0) ? 32'b1000 : 32'b0010));
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_level", 32'(level), 8);
    chk("full_stall", 32'(stall_cnt), 4);
    chk("full_pop_no_grant", 32'(src_ready), 0);
    tick();
    expect_evt(3, 8'h23, 16'h0303);
    @(negedge clk);
    chk("full_resume_grant", 32'(src_ready), 32'b1000);
    chk("full_resume_level", 32'(level), 7);
    chk("full_resume_stall", 32'(stall_cnt), 5);
    tick();
    clear_src();
    drain();
    chk("full_stall_after", 32'(stall_cnt), 5);

    // Simultaneous push/pop holding level at 3
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) out_ready = 1'b1;
      set_src(0, 1'b1, 8'(8'h60 + k), 16'(16'h0600 + k));
      expect_evt(0, 8'h60 + k, 16'h0600 + k);
      @(negedge clk);
      chk("pp_grant", 32'(src_ready), 32'b0001);
      if (k >= 3) chk("pp_level", 32'(level), 3);
      tick();
    end
    clear_src();
    drain();

    // Reset mid-stream at level 5, rr_ptr moved off 0 first
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_src(1, 1'b1, 8'(8'h70 + k), 16'(16'h0700 + k));
      expect_evt(1, 8'h70 + k, 16'h0700 + k);
      tick();
    end
    set_src(0, 1'b1, 8'h0A, 16'h0A0A);
    set_src(1, 1'b1, 8'h1B, 16'h1B1B);
    @(negedge clk);
    chk("mid_level", 32'(level), 5);
    tick();
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_stall", 32'(stall_cnt), 0);
    chk("mid_rst_ready", 32'(src_ready), 0);
    tick();
    reset = 1'b1;
    expect_evt(0, 8'h0A, 16'h0A0A);
    @(negedge clk);
    chk("mid_first_grant", 32'(src_ready), 32'b0001);
    tick();
    clear_src();
    drain();

    // Stall counter saturation
    tick();
    out_ready = 1'b0;
    set_src(0, 1'b1, 8'h7F, 16'h7F7F);
    for (int k = 0; k < 8; k++) expect_evt(0, 8'h7F, 16'h7F7F);
    repeat (108) tick();
    @(negedge clk);
    chk("sat_level", 32'(level), 8);
    chk("sat_stall_100", 32'(stall_cnt), 100);
    repeat (65500) @(posedge clk);
    @(negedge clk);
    chk("sat_stall_max", 32'(stall_cnt), 32'hFFFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat_no_wrap", 32'(stall_cnt), 32'hFFFF);
    tick();
    clear_src();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spike_arbiter.md
# spike_arbiter

Merges spike events from up to N neuron sheets into the single spike stream that feeds `spike2letter`. Each cycle it grants at most one pending spike, using round-robin order. Granted spikes are tagged with their source index and buffered in a small FIFO. The FIFO drains through a valid/ready handshake, so multiple sheets can share one decoder without losing simultaneous spikes.

## Interface
- `N_SRC`, default 4: number of requesting sheets (2–16).
- `ID_W`, default 8: neuron id width.
- `V_W`, default 16: membrane voltage width.
- `DEPTH`, default 8: FIFO entries (power of two, ≥2).
- `SRC_W`, default `$clog2(N_SRC)`: source tag width (derived).

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `src_valid`  in  N_SRC  per-source spike pending.
- `src_id`  in  N_SRC*ID_W  packed neuron ids; source i occupies `[i*ID_W +: ID_W]`.
- `src_v`  in  N_SRC*V_W  packed voltages, same packing.
- `src_ready`  out  N_SRC  one-hot grant; the spike is consumed this cycle.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  downstream accepts the head.
- `out_src`  out  SRC_W  source tag of the head entry.
- `out_id`  out  ID_W  neuron id of the head entry.
- `out_v`  out  V_W  voltage of the head entry.
- `level`  out  `$clog2(DEPTH)+1`  current FIFO occupancy.
- `stall_cnt`  out  16  saturating count of stalled cycles.

## Operation
- **Eligibility:** source i is eligible when `src_valid[i]=1` and `src_id[i]!=0`. Id 0 means "no spike" and is never granted. A valid source with id 0 gets `src_ready=0`.
- **Grant:** when `level<DEPTH`, grant the first eligible source scanning from `rr_ptr` upward, with wrap-around. `src_ready` is combinational from the current inputs and state. At most one bit is set.
- **Pointer update:** on a grant to source g, `rr_ptr <= (g+1) mod N_SRC`. With no grant, `rr_ptr` holds.
- **Push:** a grant writes {g, id, v} at the tail.
- **Pop:** when `out_valid && out_ready`, the head is removed.
- **Full FIFO:** when `level==DEPTH`, nothing is granted, even if a pop occurs in the same cycle. This removes the ready→grant combinational path.
- **Empty FIFO:** when `level==0`, `out_valid=0` and the out_* data values are don't-care.
- **Simultaneous push and pop:** when neither full nor empty, `level` is unchanged and both pointers advance.
- **Stall counting:** `stall_cnt` increments when any source is eligible and no grant issues. It saturates at 0xFFFF.
- **Sources:** must hold `src_valid`, `src_id` and `src_v` stable until granted. The arbiter does not check this.
- **Reset assert (any time):** empties the FIFO and sets `rr_ptr=0` and `stall_cnt=0`. In-flight entries are discarded.

## Timing
- Reset values: `out_valid=0`, `out_src=0`, `out_id=0`, `out_v=0`, `level=0`, `stall_cnt=0`. `src_ready` is 0 while reset is asserted.
- Latency: grant at edge t makes the entry appear at the head at t+1 when the FIFO was empty. No fall-through in the same cycle.
- Throughput: one push and one pop per cycle, sustained.
- Fairness: with all N_SRC sources continuously eligible and the FIFO never full, each source is granted exactly once per N_SRC cycles.
- Outputs `out_*` and `level` are registered. `src_ready` is the only combinational output.

## Structure
- Shared package `nonpu_pkg` holds:
  - `NONPU_ID_W=8`, `NONPU_V_W=16`;
  - `typedef struct packed {src; id; v} spike_evt_t`;
  - `NO_SPIKE_ID='0`.
- Sub-module `spike_fifo`: a generic synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, din, pop, dout, full, empty, level.
  - Registered head; storage is a register array.
- The top-level `spike_arbiter` contains the round-robin grant logic, `rr_ptr` and `stall_cnt`.

## Test plan
- **Reset:** assert reset mid-stream with level=5 → next cycle level=0, out_valid=0, stall_cnt=0. After release, the first grant goes to source 0.
- **Round-robin:** N_SRC=4, all valid with ids 0x11/0x22/0x33/0x44 and out_ready=1 → out_id sequence 0x11, 0x22, 0x33, 0x44, 0x11…, starting one cycle after the first grant.
- **Id-zero filter:** src0 valid with id 0, src2 valid with id 0x05 → only src_ready[2] fires, and the FIFO receives {src=2, id=0x05}.
- **Full FIFO:** out_ready=0 with 2 sources valid for 12 cycles → level stops at 8, src_ready stays 0 after the 8th grant, stall_cnt=4. Raising out_ready then pops 0x?? in arrival order, and granting resumes one cycle after level<8.
- **Simultaneous push/pop:** level=3 with a continuous grant and out_ready=1 → level stays 3 for 10 cycles, and the order is preserved.
- **Saturation:** hold the FIFO full for 70000 cycles with an eligible source → stall_cnt=0xFFFF and does not wrap.
